// File: rtl/transpose_rw_sequencer.sv
// Address/enable sequencer for the two-bank ping-pong RAM of the matrix transpose.
// Writes land row-major at 0-cycle latency; reads issue column-major one per cycle.
// Read output lags the issue by one cycle (RAM latency).
module transpose_rw_sequencer #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_command,
  input  logic              wr_ram_number,
  input  logic              rd_command,
  input  logic              rd_ram_number,
  input  logic              data_in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_finish_0,
  output logic              wr_finish_1,
  output logic              rd_finish_0,
  output logic              rd_finish_1,
  output logic [1:0]        ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [1:0]        ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram0_q,
  input  logic [DATA_W-1:0] ram1_q,
  output logic              data_out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_last
);

  localparam int N  = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(ROWS - 1);
  localparam logic [RW-1:0]     ROW_ONE   = RW'(1);
  localparam logic [CW-1:0]     COL_ONE   = CW'(1);

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_state_e;

  // ---------------------------------------------------------------------------
  // Write engine
  // ---------------------------------------------------------------------------
  logic              wr_armed_q, wr_armed_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              wr_acc;
  logic              wr_last;

  assign wr_acc  = wr_armed_q && data_in_valid;
  assign wr_last = wr_acc && (wcnt_q == LAST_ADDR);

  // Write strobes follow the live bank select; the address is the beat count.
  always_comb begin
    ram_we = 2'b00;
    if (wr_acc) begin
      ram_we[wr_ram_number] = 1'b1;
    end
  end

  assign ram_waddr   = wcnt_q;
  assign ram_wdata   = data_in;
  assign wr_finish_0 = wr_last && !wr_ram_number;
  assign wr_finish_1 = wr_last &&  wr_ram_number;

  // Command re-arms from address 0 and wins over the beat bookkeeping, which
  // also covers the back-to-back case (command on the finish beat).
  always_comb begin
    wr_armed_d = wr_armed_q;
    wcnt_d     = wcnt_q;
    if (wr_command) begin
      wr_armed_d = 1'b1;
      wcnt_d     = '0;
    end else if (wr_last) begin
      wr_armed_d = 1'b0;
      wcnt_d     = '0;
    end else if (wr_acc) begin
      wcnt_d     = wcnt_q + ADDR_ONE;
    end
  end

  // Write engine state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_armed_q <= 1'b0;
      wcnt_q     <= '0;
    end else begin
      wr_armed_q <= wr_armed_d;
      wcnt_q     <= wcnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read engine
  // ---------------------------------------------------------------------------
  rd_state_e         rd_state_q, rd_state_d;
  logic [RW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     rc_q, rc_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              rd_pending_q, rd_pending_d;
  logic              rd_issue;
  logic              rd_last;

  assign rd_issue = (rd_state_q == RD_RUN);
  assign rd_last  = rd_issue && (raddr_q == LAST_ADDR);

  // One read per cycle in RD_RUN, to the live read bank.
  always_comb begin
    ram_re = 2'b00;
    if (rd_issue) begin
      ram_re[rd_ram_number] = 1'b1;
    end
  end

  assign ram_raddr   = raddr_q;
  assign rd_finish_0 = rd_last && !rd_ram_number;
  assign rd_finish_1 = rd_last &&  rd_ram_number;

  // Column-major walk: rows advance by adding COLS, the next column starts at
  // the column index itself. A command landing on the finish cycle is treated
  // like an already-pending one so the next frame still follows without a bubble.
  always_comb begin
    rd_state_d   = rd_state_q;
    rr_d         = rr_q;
    rc_d         = rc_q;
    raddr_d      = raddr_q;
    rd_pending_d = rd_pending_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_command) begin
          rd_state_d = RD_RUN;
          rr_d       = '0;
          rc_d       = '0;
          raddr_d    = '0;
        end
      end
      RD_RUN: begin
        if (rd_last) begin
          rr_d         = '0;
          rc_d         = '0;
          raddr_d      = '0;
          rd_pending_d = 1'b0;
          if (!(rd_pending_q || rd_command)) begin
            rd_state_d = RD_IDLE;
          end
        end else begin
          if (rd_command) begin
            rd_pending_d = 1'b1;
          end
          if (rr_q == ROW_LAST) begin
            rr_d    = '0;
            rc_d    = rc_q + COL_ONE;
            raddr_d = ADDR_W'(rc_q) + ADDR_ONE;
          end else begin
            rr_d    = rr_q + ROW_ONE;
            raddr_d = raddr_q + COL_STEP;
          end
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase
  end

  // Read engine state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q   <= RD_IDLE;
      rr_q         <= '0;
      rc_q         <= '0;
      raddr_q      <= '0;
      rd_pending_q <= 1'b0;
    end else begin
      rd_state_q   <= rd_state_d;
      rr_q         <= rr_d;
      rc_q         <= rc_d;
      raddr_q      <= raddr_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: aligned with the RAM's one-cycle read latency
  // ---------------------------------------------------------------------------
  logic dout_vld_q;
  logic dout_last_q;
  logic rd_bank_q;

  // Delay issue/finish by one cycle and remember which bank each read targeted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_vld_q  <= 1'b0;
      dout_last_q <= 1'b0;
      rd_bank_q   <= 1'b0;
    end else begin
      dout_vld_q  <= rd_issue;
      dout_last_q <= rd_last;
      if (rd_issue) begin
        rd_bank_q <= rd_ram_number;
      end
    end
  end

  assign data_out_valid = dout_vld_q;
  assign data_out_last  = dout_last_q;
  // Held at zero between frames so idle RAM output never leaks out.
  assign data_out       = dout_vld_q ? (rd_bank_q ? ram1_q : ram0_q) : '0;

endmodule

// File: tb/tb_transpose_rw_sequencer.sv
// Bench for transpose_rw_sequencer (4x4): directed scenarios then random traffic,
// checked cycle by cycle against a queue-based frame model and a shadow memory.
module tb_transpose_rw_sequencer;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int N    = ROWS * COLS;
  localparam int DW   = 16;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_command, wr_ram_number, rd_command, rd_ram_number;
  logic          data_in_valid;
  logic [DW-1:0] data_in;
  logic          wr_finish_0, wr_finish_1, rd_finish_0, rd_finish_1;
  logic [1:0]    ram_we, ram_re;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram0_q, ram1_q, data_out;
  logic          data_out_valid, data_out_last;

  always #5 clk = ~clk;

  transpose_rw_sequencer #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_command(wr_command), .wr_ram_number(wr_ram_number),
    .rd_command(rd_command), .rd_ram_number(rd_ram_number),
    .data_in_valid(data_in_valid), .data_in(data_in),
    .wr_finish_0(wr_finish_0), .wr_finish_1(wr_finish_1),
    .rd_finish_0(rd_finish_0), .rd_finish_1(rd_finish_1),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr),
    .ram0_q(ram0_q), .ram1_q(ram1_q),
    .data_out_valid(data_out_valid), .data_out(data_out), .data_out_last(data_out_last)
  );

  // Two RAM banks, read-before-write, one-cycle read latency.
  logic [DW-1:0] mem0 [N];
  logic [DW-1:0] mem1 [N];
  always @(posedge clk) begin
    if (ram_re[0]) ram0_q <= mem0[ram_raddr];
    if (ram_re[1]) ram1_q <= mem1[ram_raddr];
    if (ram_we[0]) mem0[ram_waddr] <= ram_wdata;
    if (ram_we[1]) mem1[ram_waddr] <= ram_wdata;
  end

  // Reference model state
  logic [DW-1:0] shadow [2][N];
  bit            m_armed;
  int            m_wcnt;
  int            rq[$];      // addresses still to issue in the current read frame
  bit            m_pend;
  bit            m_dv, m_last;
  logic [DW-1:0] m_dout;

  int n_asserts = 0;
  int n_fail    = 0;
  int dv_run, dv_max, fin0_cnt, fin1_cnt, rfin_cnt;
  bit cap_en = 1'b0;
  int cap[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        rq.push_back(r * COLS + c);
  endtask

  task automatic model_reset();
    m_armed = 0; m_wcnt = 0; rq.delete(); m_pend = 0; m_dv = 0; m_last = 0; m_dout = '0;
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic step(input logic wc, input logic wb, input logic rc, input logic rb,
                      input logic dv, input logic [DW-1:0] din);
    bit acc, run;
    int a;
    @(negedge clk);
    wr_command = wc; wr_ram_number = wb; rd_command = rc; rd_ram_number = rb;
    data_in_valid = dv; data_in = din;
    #1;
    acc = m_armed && dv;
    run = rq.size() > 0;
    chk("ram_we", ram_we, acc ? (wb ? 2 : 1) : 0);
    if (acc) chk("ram_waddr", ram_waddr, m_wcnt);
    chk("ram_wdata", ram_wdata, din);
    chk("wr_finish_0", wr_finish_0, acc && m_wcnt == N-1 && !wb);
    chk("wr_finish_1", wr_finish_1, acc && m_wcnt == N-1 && wb);
    chk("ram_re", ram_re, run ? (rb ? 2 : 1) : 0);
    if (run) chk("ram_raddr", ram_raddr, rq[0]);
    chk("rd_finish_0", rd_finish_0, run && rq.size() == 1 && !rb);
    chk("rd_finish_1", rd_finish_1, run && rq.size() == 1 && rb);
    chk("data_out_valid", data_out_valid, m_dv);
    chk("data_out_last", data_out_last, m_last);
    if (m_dv) chk("data_out", data_out, m_dout);
    if (data_out_valid) begin dv_run++; if (dv_run > dv_max) dv_max = dv_run; end
    else dv_run = 0;
    if (wr_finish_0) fin0_cnt++;
    if (wr_finish_1) fin1_cnt++;
    if (rd_finish_0 || rd_finish_1) rfin_cnt++;
    if (cap_en && data_out_valid) cap.push_back(int'(data_out));
    @(posedge clk);
    // read side (sees memory before this cycle's write)
    if (run) begin
      a = rq.pop_front();
      m_dv = 1; m_dout = shadow[rb][a]; m_last = (rq.size() == 0);
      if (rq.size() == 0) begin
        if (m_pend || rc) begin push_frame(); m_pend = 0; end
      end else if (rc) m_pend = 1;
    end else begin
      m_dv = 0; m_last = 0;
      if (rc) push_frame();
    end
    // write side: a frame is exactly N accepted beats from a command
    if (acc) shadow[wb][m_wcnt] = din;
    if (wc) begin m_armed = 1; m_wcnt = 0; end
    else if (acc) begin
      if (m_wcnt == N-1) begin m_armed = 0; m_wcnt = 0; end
      else m_wcnt++;
    end
  endtask

  task automatic hard_reset();
    @(negedge clk);
    wr_command = 0; wr_ram_number = 0; rd_command = 0; rd_ram_number = 0;
    data_in_valid = 0; data_in = '0;
    rst_n = 1'b0;
    #1;
    chk("rst ram_we", ram_we, 0);
    chk("rst ram_re", ram_re, 0);
    chk("rst ram_waddr", ram_waddr, 0);
    chk("rst ram_raddr", ram_raddr, 0);
    chk("rst finishes", {wr_finish_0, wr_finish_1, rd_finish_0, rd_finish_1}, 0);
    chk("rst data_out_valid", data_out_valid, 0);
    chk("rst data_out_last", data_out_last, 0);
    chk("rst data_out", data_out, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      mem0[i] = '0; mem1[i] = '0; shadow[0][i] = '0; shadow[1][i] = '0;
    end
    ram0_q = '0; ram1_q = '0;
    rst_n = 1'b0;
    model_reset();
    dv_run = 0; dv_max = 0;
    hard_reset();

    // Single write frame, bank 0, values 0..15
    fin0_cnt = 0;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) step(0, 0, 0, 0, 1, DW'(i));
    chk("single frame wr_finish_0 count", fin0_cnt, 1);
    // Not armed any more: beats are dropped
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 16'hdead);

    // Gapped input, same frame
    fin0_cnt = 0;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2*N; i++) step(0, 0, 0, 0, (i % 2) == 0, DW'(i / 2));
    chk("gapped frame wr_finish_0 count", fin0_cnt, 1);

    // Transposed read of bank 0
    cap.delete(); cap_en = 1; rfin_cnt = 0;
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < N + 3; i++) step(0, 0, 0, 0, 0, 0);
    cap_en = 0;
    chk("transpose sample count", cap.size(), N);
    for (int k = 0; k < N && k < cap.size(); k++)
      chk("transpose order", cap[k], (k % ROWS) * COLS + k / ROWS);
    chk("transpose rd_finish count", rfin_cnt, 1);

    // Back-to-back write: command on the bank-0 finish beat, then bank 1
    fin0_cnt = 0; fin1_cnt = 0;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) step(i == N-1, 0, 0, 0, 1, DW'(16'h100 + i));
    for (int i = 0; i < N; i++) step(0, 1, 0, 0, 1, DW'(16'h200 + i));
    chk("b2b wr_finish_0 count", fin0_cnt, 1);
    chk("b2b wr_finish_1 count", fin1_cnt, 1);

    // Pending read: second command mid-frame, bank switches to 1 at the boundary
    dv_max = 0; rfin_cnt = 0;
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) step(0, 0, i == 3 || i == 5, 0, 0, 0);
    for (int i = 0; i < N; i++) step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
    chk("pending contiguous valid", dv_max, 2*N);
    chk("pending rd_finish count", rfin_cnt, 2);

    // Reset mid-frame: 7 write beats plus an active read
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, DW'(16'h300 + i));
    step(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0);
    hard_reset();
    fin0_cnt = 0; fin1_cnt = 0; rfin_cnt = 0;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 16'hbeef);
    chk("post reset no write finish", fin0_cnt + fin1_cnt, 0);
    chk("post reset no read finish", rfin_cnt, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) step(0, 0, 0, 0, 1, DW'(16'h400 + i));
    chk("fresh frame wr_finish_0 count", fin0_cnt, 1);

    // Random traffic
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 6, DW'($urandom));
    for (int i = 0; i < 2*N + 4; i++) step(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/transpose_rw_sequencer.md
# transpose_rw_sequencer

Address and enable sequencer for the two-bank ping-pong RAM of the matrix-transpose datapath. It takes the per-frame write/read commands and bank numbers issued by the ping-pong manager and performs the actual RAM access. Incoming samples are written row-major into the selected bank, and frames are read back column-major from the other bank. It returns the per-bank `wr_finish_*` / `rd_finish_*` pulses that drive the manager's state machines.

## Interface
- `ROWS`, 8: matrix rows per frame (≥2)
- `COLS`, 8: matrix columns per frame (≥2)
- `DATA_W`, 16: sample width
- `ADDR_W`, $clog2(ROWS*COLS): RAM address width; N = ROWS*COLS words per bank

Ports:
- `clk`  in  1  single clock, all logic rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_command`  in  1  one-cycle pulse: arm a new write frame
- `wr_ram_number`  in  1  live bank select for write beats
- `rd_command`  in  1  one-cycle pulse: request a read frame
- `rd_ram_number`  in  1  live bank select for read beats
- `data_in_valid`  in  1  input sample strobe
- `data_in`  in  DATA_W  input sample
- `wr_finish_0`, `wr_finish_1`  out  1  last write beat of a frame into bank 0/1 (combinational)
- `rd_finish_0`, `rd_finish_1`  out  1  last read issue of a frame from bank 0/1 (combinational)
- `ram_we`  out  2  per-bank write enable
- `ram_waddr`  out  ADDR_W  shared write address
- `ram_wdata`  out  DATA_W  shared write data (= `data_in`)
- `ram_re`  out  2  per-bank read enable
- `ram_raddr`  out  ADDR_W  shared read address
- `ram0_q`, `ram1_q`  in  DATA_W  bank read data, 1-cycle latency after `ram_re`
- `data_out_valid`  out  1  transposed sample valid
- `data_out`  out  DATA_W  transposed sample
- `data_out_last`  out  1  with final sample of a frame

## Operation
Write engine:
- Registers: `wr_armed` and `wcnt` [0..N-1].
- `wr_command` sets `wr_armed=1` and `wcnt=0` on the next edge.
- Beats are accepted from the cycle after the command.
- A beat is accepted when `wr_armed && data_in_valid`. It drives `ram_we[wr_ram_number]=1` and `ram_waddr=wcnt`, then increments `wcnt`.
- `data_in_valid` while not armed: the beat is dropped and `ram_we` stays 0.
- `wr_finish_b` = accepted beat && `wcnt==N-1` && `wr_ram_number==b`.
- At the finish beat:
  - If `wr_command` is also high: `wcnt` returns to 0 and the engine stays armed. This is a back-to-back frame; the next beat goes to the manager's new bank.
  - Otherwise: `wr_armed` clears.

Read engine:
- States: RD_IDLE, RD_RUN.
- Counters: `rr` (row, inner loop) and `rc` (column, outer loop). The running address `raddr` = `rr*COLS+rc` is maintained by adding COLS per step; no multiplier.
- Address order: 0, COLS, 2·COLS, …, (ROWS-1)·COLS, 1, COLS+1, …, N-1.
- RD_IDLE with `rd_command`: go to RD_RUN, with `rr=rc=0`.
- RD_RUN issues one read per cycle: `ram_re[rd_ram_number]=1`, `ram_raddr=raddr`.
- `rd_finish_b` = RD_RUN && `raddr==N-1` && `rd_ram_number==b`.
- After the final issue:
  - If `rd_pending` is set: clear it, reset the counters, and stay in RD_RUN. The next frame's first issue happens the very next cycle.
  - Otherwise: go to RD_IDLE.
- `rd_command` in RD_RUN (including the finish cycle) sets `rd_pending`. A second command while pending is already set is absorbed; depth is 1.
- Output stage:
  - `data_out_valid`/`data_out_last` are `ram_re` OR-reduced / the finish condition, delayed one cycle.
  - `data_out` is muxed from `ram0_q`/`ram1_q` by the read bank registered at issue time.

Reset:
- All registers and outputs go to 0, and the read engine goes to RD_IDLE.
- Any partial frame is discarded and no finish pulse is emitted.

## Timing
- Write: 0-cycle latency; `ram_we` is coincident with the accepted `data_in_valid`.
- A write frame is exactly N accepted beats. Gaps in `data_in_valid` stall `wcnt` without error.
- Read: the first `ram_re` is issued 1 cycle after `rd_command`. Each frame occupies exactly N consecutive cycles with no bubbles.
- `data_out_valid` lags `ram_re` by 1 cycle; the whole frame output spans N cycles.
- Back-to-back read frames produce 2N contiguous valid cycles.
- Simultaneous write and read of the same bank is not checked; avoiding it is the manager's responsibility.

## Test plan
- **Single write frame** (ROWS=COLS=4): `wr_command`, then 16 valid beats of values 0..15 on bank 0 → `ram_waddr` runs 0..15. `wr_finish_0` pulses only on the beat with value 15, and `wr_armed` clears.
- **Gapped input**: same frame with `data_in_valid` low every other cycle → same address sequence. `wr_finish_0` pulses once, on the 16th accepted beat.
- **Transposed read**: bank 0 holds values 0..15, `rd_command` with bank 0 →
  - `ram_raddr` runs 0,4,8,12,1,5,…,15.
  - `data_out` = 0,4,8,12,1,…,15 starting 2 cycles after the command.
  - `data_out_last` is asserted with 15.
- **Back-to-back write**: `wr_command` asserted on the finish beat of bank 0, bank select switching to 1 → the next beat is written to bank 1 at address 0, and the engine stays armed.
- **Pending read**: `rd_command` during a bank-0 read, bank select switching to 1 →
  - bank-1 reads start the cycle after the final bank-0 issue;
  - 32 contiguous `data_out_valid` cycles.
- **Reset mid-frame**: `rst_n` low after 7 write beats and mid-read → all outputs 0 immediately. A fresh frame afterwards starts at address 0 with no spurious finish pulses.
